// File: rtl/onehot_encoder8x3_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of
// every set bit, one per output handshake, flagging the last code of each vector.
// Build option: define ENC_MSB_FIRST_EN to scan the highest set bit first;
// the default build scans the lowest set bit first.
module onehot_encoder8x3_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = 3   // must equal $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  Din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] Do,
    output logic              out_last,
    output logic [CODE_W:0]   code_cnt,
    output logic              empty_pulse
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    pending_q, pending_d;
    logic [CODE_W:0]     code_cnt_q, code_cnt_d;
    logic                empty_q, empty_d;
    logic [CODE_W-1:0]   scan_idx;
    logic                one_left;

    // Pick the next bit to emit from the registered pending vector only.
    always_comb begin
        scan_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        // Ascending loop: the last hit is the highest set bit.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (pending_q[i]) scan_idx = CODE_W'(i);
        end
`else
        // Descending loop: the last hit is the lowest set bit.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending_q[i]) scan_idx = CODE_W'(i);
        end
`endif
        one_left = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    end

    // Next-state logic for the IDLE/EMIT handshake sequencer.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        code_cnt_d = code_cnt_q;
        empty_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    code_cnt_d = '0;
                    if (Din != '0) begin
                        pending_d = Din;
                        state_d   = StEmit;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    pending_d  = pending_q & ~(WIDTH'(1) << scan_idx);
                    code_cnt_d = code_cnt_q + (CODE_W + 1)'(1);
                    if (one_left) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset discarding any pending vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            code_cnt_q <= '0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            code_cnt_q <= code_cnt_d;
            empty_q    <= empty_d;
        end
    end

    // Outputs derive from registered state; in_ready is also held low during reset.
    always_comb begin
        in_ready    = (state_q == StIdle) && !rst;
        out_valid   = (state_q == StEmit);
        Do          = out_valid ? scan_idx : '0;
        out_last    = out_valid && one_left;
        code_cnt    = code_cnt_q;
        empty_pulse = empty_q;
    end

endmodule

// File: tb/tb_onehot_encoder8x3_seq.sv
// Directed self-checking bench for onehot_encoder8x3_seq; honours ENC_MSB_FIRST_EN.
module tb_onehot_encoder8x3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Din;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] Do;
    logic       out_last;
    logic [3:0] code_cnt;
    logic       empty_pulse;

    int checks = 0;
    int errors = 0;

    onehot_encoder8x3_seq #(.WIDTH(8), .CODE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Din        (Din),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Do         (Do),
        .out_last   (out_last),
        .code_cnt   (code_cnt),
        .empty_pulse(empty_pulse)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected index of the n-th code emitted for 8'hFF.
    function automatic logic [2:0] ff_code(input int n);
`ifdef ENC_MSB_FIRST_EN
        return 3'(7 - n);
`else
        return 3'(n);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; Din = '0; out_ready = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || Do !== 3'd0 || out_last !== 1'b0
            || code_cnt !== 4'd0 || empty_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b Do=%0d last=%b cnt=%0d empty=%b, want 0s",
                     in_ready, out_valid, Do, out_last, code_cnt, empty_pulse);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        Din = 8'b0000_0100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Do !== 3'd2 || out_last !== 1'b1 || code_cnt !== 4'd0) begin
            errors++;
            $display("FAIL single_code: valid=%b Do=%0d last=%b cnt=%0d, want 1 2 1 0",
                     out_valid, Do, out_last, code_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || code_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_done: valid=%b ready=%b cnt=%0d, want 0 1 1",
                     out_valid, in_ready, code_cnt);
        end
    endtask

    task automatic test_multi();
        logic [2:0] exp [3];
`ifdef ENC_MSB_FIRST_EN
        exp = '{3'd7, 3'd5, 3'd0};
`else
        exp = '{3'd0, 3'd5, 3'd7};
`endif
        Din = 8'b1010_0001; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || Do !== exp[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL multi_code%0d: valid=%b Do=%0d last=%b, want 1 %0d %b",
                         i, out_valid, Do, out_last, exp[i], (i == 2));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || code_cnt !== 4'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL multi_done: valid=%b cnt=%0d ready=%b, want 0 3 1",
                     out_valid, code_cnt, in_ready);
        end
    endtask

    task automatic test_empty();
        Din = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (empty_pulse !== 1'b1 || out_valid !== 1'b0 || code_cnt !== 4'd0 || in_ready !== 1'b1)
        begin
            errors++;
            $display("FAIL empty_accept: empty=%b valid=%b cnt=%0d ready=%b, want 1 0 0 1",
                     empty_pulse, out_valid, code_cnt, in_ready);
        end
        step();
        checks++;
        if (empty_pulse !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_one_cycle: empty=%b valid=%b, want 0 0", empty_pulse, out_valid);
        end
    endtask

    task automatic test_stall();
        Din = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || Do !== ff_code(i) || out_last !== (i == 7)) begin
                errors++;
                $display("FAIL stall_code%0d: valid=%b Do=%0d last=%b, want 1 %0d %b",
                         i, out_valid, Do, out_last, ff_code(i), (i == 7));
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || Do !== ff_code(i) || out_last !== (i == 7)
                || code_cnt !== 4'(i)) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b Do=%0d last=%b cnt=%0d, want 1 %0d %b %0d",
                         i, out_valid, Do, out_last, code_cnt, ff_code(i), (i == 7), i);
            end
            out_ready = 1'b1;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || code_cnt !== 4'd8 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: valid=%b cnt=%0d ready=%b, want 0 8 1",
                     out_valid, code_cnt, in_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        Din = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b1 || Do !== ff_code(3) || code_cnt !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset: valid=%b Do=%0d cnt=%0d, want 1 %0d 3",
                     out_valid, Do, code_cnt, ff_code(3));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || code_cnt !== 4'd0 || in_ready !== 1'b0 || Do !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b cnt=%0d ready=%b Do=%0d, want 0 0 0 0",
                     out_valid, code_cnt, in_ready, Do);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
        Din = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Do !== 3'd4 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_code: valid=%b Do=%0d last=%b, want 1 4 1",
                     out_valid, Do, out_last);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || code_cnt !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_done: valid=%b cnt=%0d, want 0 1", out_valid, code_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp [3];
`ifdef ENC_MSB_FIRST_EN
        exp = '{3'd7, 3'd5, 3'd0};
`else
        exp = '{3'd0, 3'd5, 3'd7};
`endif
        Din = 8'b1010_0001; in_valid = 1'b1; out_ready = 1'b1;
        step();
        // Keep offering a different vector while the first one drains.
        Din = 8'b0000_0010;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || Do !== exp[i]) begin
                errors++;
                $display("FAIL b2b_emit%0d: ready=%b valid=%b Do=%0d, want 0 1 %0d",
                         i, in_ready, out_valid, Do, exp[i]);
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || code_cnt !== 4'd3) begin
            errors++;
            $display("FAIL b2b_idle: ready=%b valid=%b cnt=%0d, want 1 0 3",
                     in_ready, out_valid, code_cnt);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Do !== 3'd1 || out_last !== 1'b1 || code_cnt !== 4'd0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b Do=%0d last=%b cnt=%0d, want 1 1 1 0",
                     out_valid, Do, out_last, code_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || code_cnt !== 4'd1) begin
            errors++;
            $display("FAIL b2b_done: valid=%b cnt=%0d, want 0 1", out_valid, code_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_stall();
        test_reset_mid_emit();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
